// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  // Shortest legal bit period in clk cycles; smaller divisors are clamped to this.
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/uart_fifo.sv
// Generic synchronous FIFO: push/pop in the same cycle, pop_data shows the head word.
// No added latency; pushes are dropped while full and pops are ignored while empty.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with FIFO; tx falls 2 edges after a write into an idle, empty unit; s_ready drops when full.
// Define UART_TX_PARITY_EN to build in the optional parity bit (parity_en / parity_odd).
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_BITS-1:0]            s_data,
  input  logic [DIV_W-1:0]                div,
  input  logic                            stop2,
  input  logic                            parity_en,
  input  logic                            parity_odd,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int BC_W = $clog2(DATA_BITS);

  state_t               state, state_nxt;
  logic [DIV_W-1:0]     div_q, timer, bit_len;
  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shreg, pop_data;
  logic                 stop2_q, bit_done, stop_last;
  logic                 pop, fifo_full, fifo_empty, tx_nxt;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_bit;
`else
  logic unused_parity;
  assign unused_parity = parity_en ^ parity_odd;
`endif

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s_valid && s_ready),
    .push_data (s_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign s_ready   = !fifo_full;
  assign busy      = (state != IDLE) || (fifo_level != '0);
  assign bit_len   = (div_q < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_q;
  assign bit_done  = (timer == bit_len - 1'b1);
  assign stop_last = !stop2_q || (bit_cnt == BC_W'(1));

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_nxt    = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (bit_done) state_nxt = DATA;
      end
      DATA: begin
        tx_nxt = shreg[0];
        if (bit_done && bit_cnt == BC_W'(DATA_BITS-1)) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = par_en_q ? PARITY : STOP;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_nxt = par_bit;
        if (bit_done) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (bit_done && stop_last) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every pop starts a frame, so the pop edge is where the frame's settings are captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      timer    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      div_q    <= '0;
      stop2_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      tx    <= tx_nxt;
      if (state == IDLE || bit_done) timer <= '0;
      else                           timer <= timer + 1'b1;
      if (bit_done) bit_cnt <= (state_nxt != state) ? '0 : bit_cnt + 1'b1;
      if (pop) begin
        shreg    <= pop_data;
        div_q    <= div;
        stop2_q  <= stop2;
`ifdef UART_TX_PARITY_EN
        par_en_q <= parity_en;
        par_bit  <= (^pop_data) ^ parity_odd;
`endif
      end else if (state == DATA && bit_done) begin
        shreg <= shreg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: each task drives one scenario and checks tx waveforms and status inline.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic [15:0] div = 16'd4;
  logic        stop2 = 1'b0;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_level;

  int checks = 0;
  int failures = 0;

  uart_tx_cfg #(.DATA_BITS(8), .DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .div        (div),
    .stop2      (stop2),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_fall(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 300 && !ok) begin
      if (tx === 1'b0) ok = 1'b1;
      else begin
        step();
        n++;
      end
    end
  endtask

  task automatic capture(input int n, output logic [255:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      w[i] = tx;
      step();
    end
  endtask

  function automatic logic [255:0] expand(input logic [63:0] frame, input int nbits, input int bitlen);
    logic [255:0] r = '0;
    for (int i = 0; i < nbits; i++)
      for (int c = 0; c < bitlen; c++)
        r[i*bitlen + c] = frame[i];
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks += 4;
    if (tx !== 1'b1)          begin failures++; $display("FAIL reset_tx got=%b want=1", tx); end
    if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (fifo_level !== 3'd0)  begin failures++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    if (s_ready !== 1'b1)     begin failures++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
    step();
    step();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset tx=%b busy=%b want tx=1 busy=0", tx, busy); end
  endtask

  task automatic test_basic_8n1();
    logic [255:0] w;
    div = 16'd4; stop2 = 1'b0; parity_en = 1'b0;
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL basic_s_ready got=%b want=1", s_ready); end
    push_word(8'h55);
    checks += 3;
    if (tx !== 1'b1)         begin failures++; $display("FAIL basic_tx_edge1 got=%b want=1", tx); end
    if (fifo_level !== 3'd1) begin failures++; $display("FAIL basic_level got=%0d want=1", fifo_level); end
    if (busy !== 1'b1)       begin failures++; $display("FAIL basic_busy got=%b want=1", busy); end
    step();
    checks += 2;
    if (tx !== 1'b1)         begin failures++; $display("FAIL basic_tx_edge2 got=%b want=1", tx); end
    if (fifo_level !== 3'd0) begin failures++; $display("FAIL basic_level_popped got=%0d want=0", fifo_level); end
    step();
    checks++;
    if (tx !== 1'b0) begin failures++; $display("FAIL basic_start_at_2 got=%b want=0", tx); end
    capture(40, w);
    checks++;
    if (w !== expand(64'({1'b1, 8'h55, 1'b0}), 10, 4))
      begin failures++; $display("FAIL basic_frame got=%h want=%h", w, expand(64'({1'b1, 8'h55, 1'b0}), 10, 4)); end
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_end tx=%b busy=%b want tx=1 busy=0", tx, busy); end
  endtask

  task automatic test_parity();
    logic [255:0] w;
    logic [255:0] exp_even, exp_odd;
    bit ok;
    div = 16'd2; stop2 = 1'b0; parity_en = 1'b1;
`ifdef UART_TX_PARITY_EN
    exp_even = expand(64'(11'b11000001110), 11, 2);
    exp_odd  = expand(64'(11'b10000001110), 11, 2);
`else
    exp_even = expand(64'(11'b11000001110), 11, 2);
    exp_odd  = expand(64'(11'b11000001110), 11, 2);
`endif
    parity_odd = 1'b0;
    push_word(8'h07);
    wait_fall(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL parity_even_timeout got=no_start want=start"); end
    capture(22, w);
    checks++;
    if (w !== exp_even) begin failures++; $display("FAIL parity_even got=%h want=%h", w, exp_even); end
    parity_odd = 1'b1;
    push_word(8'h07);
    wait_fall(ok);
    capture(22, w);
    checks++;
    if (w !== exp_odd) begin failures++; $display("FAIL parity_odd got=%h want=%h", w, exp_odd); end
    parity_en = 1'b0;
    parity_odd = 1'b0;
  endtask

  task automatic test_stop2();
    logic [255:0] w, e;
    bit ok;
    div = 16'd3; stop2 = 1'b1;
    push_word(8'h00);
    push_word(8'hFF);
    checks++;
    if (fifo_level !== 3'd1) begin failures++; $display("FAIL stop2_push_pop_level got=%0d want=1", fifo_level); end
    wait_fall(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stop2_timeout got=no_start want=start"); end
    capture(66, w);
    e = expand(64'({1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0}), 22, 3);
    checks++;
    if (w !== e) begin failures++; $display("FAIL stop2_frames got=%h want=%h", w, e); end
    stop2 = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [255:0] w, e;
    logic [7:0] words [6];
    bit ok;
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    div = 16'd2; stop2 = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          int n = 0;
          s_data  = words[k];
          s_valid = 1'b1;
          while (!s_ready && n < 200) begin
            step();
            n++;
          end
          checks++;
          if (!s_ready) begin failures++; $display("FAIL full_accept_timeout word=%0d got=s_ready0 want=s_ready1", k); end
          step();
          if (k == 4) begin
            checks += 2;
            if (fifo_level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d want=4", fifo_level); end
            if (s_ready !== 1'b0)    begin failures++; $display("FAIL full_s_ready got=%b want=0", s_ready); end
          end
        end
        s_valid = 1'b0;
      end
      begin
        wait_fall(ok);
        capture(120, w);
      end
    join
    checks++;
    if (!ok) begin failures++; $display("FAIL full_timeout got=no_start want=start"); end
    e = expand({4'h0, 1'b1, 8'h66, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'h44, 1'b0,
                1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}, 60, 2);
    checks++;
    if (w !== e) begin failures++; $display("FAIL full_order got=%h want=%h", w, e); end
  endtask

  task automatic test_div();
    logic [255:0] w, e;
    bit ok;
    stop2 = 1'b0;
    div = 16'd0;
    push_word(8'h3C);
    wait_fall(ok);
    capture(20, w);
    checks++;
    if (w !== expand(64'(10'b1001111000), 10, 2))
      begin failures++; $display("FAIL div0_frame got=%h want=%h", w, expand(64'(10'b1001111000), 10, 2)); end
    div = 16'd5;
    push_word(8'h0F);
    push_word(8'hF0);
    wait_fall(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL div_change_timeout got=no_start want=start"); end
    div = 16'd2;
    capture(70, w);
    e = expand(64'({1'b1, 8'h0F, 1'b0}), 10, 5) | (expand(64'({1'b1, 8'hF0, 1'b0}), 10, 2) << 50);
    checks++;
    if (w !== e) begin failures++; $display("FAIL div_change got=%h want=%h", w, e); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit saw_low = 1'b0;
    bit saw_busy = 1'b0;
    div = 16'd4;
    push_word(8'hA5);
    push_word(8'h3C);
    wait_fall(ok);
    for (int i = 0; i < 10; i++) step();
    #2 reset = 1'b1;
    #1;
    checks += 4;
    if (tx !== 1'b1)         begin failures++; $display("FAIL midreset_tx got=%b want=1", tx); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL midreset_busy got=%b want=0", busy); end
    if (fifo_level !== 3'd0) begin failures++; $display("FAIL midreset_level got=%0d want=0", fifo_level); end
    if (s_ready !== 1'b1)    begin failures++; $display("FAIL midreset_s_ready got=%b want=1", s_ready); end
    step();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx !== 1'b1) saw_low = 1'b1;
      if (busy !== 1'b0) saw_busy = 1'b1;
    end
    checks++;
    if (saw_low || saw_busy) begin failures++; $display("FAIL midreset_resumed tx_low=%b busy=%b want both 0", saw_low, saw_busy); end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_parity();
    test_stop2();
    test_fifo_full();
    test_div();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
